// File: rtl/regs_wr_sched_pkg.sv
// cpu_pkg: shared register-file widths, write-source indices and a one-hot register mask helper
package cpu_pkg;
  localparam int REG_W = 4;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 16;
  localparam int NUM_SRC = 3;
  localparam int SRC_LD = 0;
  localparam int SRC_MD = 1;
  localparam int SRC_ALU = 2;
  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic en, input reg_idx_t r);
    return en ? NUM_REGS'(1) << r : '0;
  endfunction
endpackage

// File: rtl/regs_wr_sched_if.sv
// regs_wr_sched_if: result-source handshakes, decode scoreboard ports and register-file write port
interface regs_wr_sched_if;
  import cpu_pkg::*;
  logic alu_req, alu_ack, ld_req, ld_ack, md_req, md_ack;
  reg_idx_t alu_reg, ld_reg, md_reg;
  data_t alu_data, ld_data, md_data;
  logic sb_set;
  reg_idx_t sb_reg, chk_reg_1, chk_reg_2;
  logic hazard;
  logic [NUM_REGS-1:0] busy;
  logic wr_en;
  reg_idx_t wr_reg;
  data_t wr_data;
  modport master (
    output alu_req, alu_reg, alu_data, ld_req, ld_reg, ld_data, md_req, md_reg, md_data,
    output sb_set, sb_reg, chk_reg_1, chk_reg_2,
    input alu_ack, ld_ack, md_ack, hazard, busy, wr_en, wr_reg, wr_data
  );
  modport slave (
    input alu_req, alu_reg, alu_data, ld_req, ld_reg, ld_data, md_req, md_reg, md_data,
    input sb_set, sb_reg, chk_reg_1, chk_reg_2,
    output alu_ack, ld_ack, md_ack, hazard, busy, wr_en, wr_reg, wr_data
  );
endinterface

// File: rtl/regs_wr_sched_arb.sv
// regs_wr_arb: fixed-priority arbiter (index 0 highest) where a requester refused MAX_WAIT cycles jumps ahead
module regs_wr_arb #(
  parameter int N = 3,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  logic [3:0] cnt [N];
  logic [N-1:0] aged, sel;
  always_comb begin
    for (int i = 0; i < N; i++) aged[i] = req[i] && cnt[i] == MW;
    sel = |aged ? aged : req;
    gnt = rst ? '0 : sel & ~(sel - N'(1));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    else
      for (int i = 0; i < N; i++) cnt[i] <= (!req[i] || gnt[i]) ? '0 : cnt[i] == MW ? cnt[i] : cnt[i] + 4'd1;
endmodule

// File: rtl/regs_wr_sched.sv
// regs_wr_sched: shares the register-file write port among load, mul/div and ALU results and flags decode hazards
module regs_wr_sched
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input logic clk,
  input logic rst,
  regs_wr_sched_if.slave bus
);
  logic [NUM_SRC-1:0] req, gnt;
  reg_idx_t g_reg;
  data_t g_data;
  assign req[SRC_LD] = bus.ld_req;
  assign req[SRC_MD] = bus.md_req;
  assign req[SRC_ALU] = bus.alu_req;
  regs_wr_arb #(.N(NUM_SRC), .MAX_WAIT(MAX_WAIT)) u_arb (.clk(clk), .rst(rst), .req(req), .gnt(gnt));
  assign bus.ld_ack = gnt[SRC_LD];
  assign bus.md_ack = gnt[SRC_MD];
  assign bus.alu_ack = gnt[SRC_ALU];
  always_comb begin
    g_reg = gnt[SRC_LD] ? bus.ld_reg : gnt[SRC_MD] ? bus.md_reg : bus.alu_reg;
    g_data = gnt[SRC_LD] ? bus.ld_data : gnt[SRC_MD] ? bus.md_data : bus.alu_data;
  end
  // a same-edge sb_set re-marks the register after the grant clears it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.busy <= '0;
      bus.wr_en <= 1'b0;
      bus.wr_reg <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.busy <= (bus.busy & ~reg_mask(|gnt, g_reg)) | reg_mask(bus.sb_set, bus.sb_reg);
      bus.wr_en <= |gnt;
      if (|gnt) begin
        bus.wr_reg <= g_reg;
        bus.wr_data <= g_data;
      end
    end
  assign bus.hazard = bus.busy[bus.chk_reg_1] | bus.busy[bus.chk_reg_2]
    | (bus.wr_en & (bus.wr_reg == bus.chk_reg_1 | bus.wr_reg == bus.chk_reg_2));
endmodule

// File: tb/tb_regs_wr_sched.sv
// tb_regs_wr_sched: directed and random traffic checked against a queue-based write scoreboard
module tb_regs_wr_sched;
  import cpu_pkg::*;
  localparam int MAX_WAIT = 4;
  typedef struct packed { reg_idx_t r; data_t d; } wr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  regs_wr_sched_if bus ();
  regs_wr_sched #(.MAX_WAIT(MAX_WAIT)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_tests = 0;
  int n_fail = 0;
  logic s_req [NUM_SRC];
  reg_idx_t s_reg [NUM_SRC];
  data_t s_data [NUM_SRC];
  logic sb_set = 1'b0;
  reg_idx_t sb_reg = '0, c1 = '0, c2 = '0;
  int waited [NUM_SRC];
  logic [NUM_REGS-1:0] m_busy = '0;
  logic m_wr_en = 1'b0;
  reg_idx_t m_wr_reg = '0;
  data_t m_wr_data = '0;
  wr_t exp_q [$];
  logic [2:0] obs_ack;
  logic obs_haz, obs_wr_en;
  logic [NUM_REGS-1:0] obs_busy;
  reg_idx_t obs_wr_reg;
  data_t obs_wr_data;
  assign bus.ld_req = s_req[SRC_LD];
  assign bus.ld_reg = s_reg[SRC_LD];
  assign bus.ld_data = s_data[SRC_LD];
  assign bus.md_req = s_req[SRC_MD];
  assign bus.md_reg = s_reg[SRC_MD];
  assign bus.md_data = s_data[SRC_MD];
  assign bus.alu_req = s_req[SRC_ALU];
  assign bus.alu_reg = s_reg[SRC_ALU];
  assign bus.alu_data = s_data[SRC_ALU];
  assign bus.sb_set = sb_set;
  assign bus.sb_reg = sb_reg;
  assign bus.chk_reg_1 = c1;
  assign bus.chk_reg_2 = c2;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic put(input int s, input reg_idx_t r, input data_t d);
    s_req[s] = 1'b1;
    s_reg[s] = r;
    s_data[s] = d;
  endtask
  // starved sources first (ld, md, alu order), otherwise plain ld > md > alu
  function automatic int pick();
    for (int i = 0; i < NUM_SRC; i++) if (s_req[i] && waited[i] >= MAX_WAIT) return i;
    for (int i = 0; i < NUM_SRC; i++) if (s_req[i]) return i;
    return -1;
  endfunction
  task automatic cycle();
    int g;
    logic [2:0] e_ack;
    @(negedge clk);
    g = rst ? -1 : pick();
    e_ack = g < 0 ? 3'b000 : 3'(1 << g);
    obs_ack = {bus.alu_ack, bus.md_ack, bus.ld_ack};
    obs_haz = bus.hazard;
    obs_wr_en = bus.wr_en;
    obs_busy = bus.busy;
    obs_wr_reg = bus.wr_reg;
    obs_wr_data = bus.wr_data;
    if (rst) begin
      m_busy = '0;
      m_wr_en = 1'b0;
      m_wr_reg = '0;
      m_wr_data = '0;
      for (int i = 0; i < NUM_SRC; i++) waited[i] = 0;
      exp_q.delete();
    end
    check("ack", 32'(obs_ack), 32'(e_ack));
    check("busy", 32'(obs_busy), 32'(m_busy));
    check("wr_en", 32'(obs_wr_en), 32'(m_wr_en));
    check("hazard", 32'(obs_haz), 32'(m_busy[c1] | m_busy[c2] | (m_wr_en && (m_wr_reg == c1 || m_wr_reg == c2))));
    if (!m_wr_en) begin
      check("wr_reg_hold", 32'(obs_wr_reg), 32'(m_wr_reg));
      check("wr_data_hold", obs_wr_data, m_wr_data);
    end
    if (!rst) begin
      if (g >= 0) begin
        exp_q.push_back(wr_t'{r: s_reg[g], d: s_data[g]});
        m_busy[s_reg[g]] = 1'b0;
        m_wr_reg = s_reg[g];
        m_wr_data = s_data[g];
      end
      if (sb_set) m_busy[sb_reg] = 1'b1;
      m_wr_en = g >= 0;
      for (int i = 0; i < NUM_SRC; i++) waited[i] = (s_req[i] && i != g) ? waited[i] + 1 : 0;
    end
    @(posedge clk);
    #1;
    if (g >= 0) s_req[g] = 1'b0;
    sb_set = 1'b0;
  endtask
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wr_unexpected: wr_en=1 reg=%0d data=%0h with no grant pending", bus.wr_reg, bus.wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_reg", 32'(bus.wr_reg), 32'(e.r));
          check("wr_data", bus.wr_data, e.d);
        end
      end
    end
  end
  initial begin
    for (int i = 0; i < NUM_SRC; i++) begin
      s_req[i] = 1'b0;
      s_reg[i] = '0;
      s_data[i] = '0;
      waited[i] = 0;
    end
    put(SRC_LD, 4'd3, 32'h11);
    put(SRC_MD, 4'd4, 32'h22);
    put(SRC_ALU, 4'd5, 32'h33);
    repeat (2) cycle();
    check("rst_ack", 32'(obs_ack), 32'b000);
    rst = 1'b0;
    cycle();
    check("prio_ld", 32'(obs_ack), 32'b001);
    cycle();
    check("prio_md", 32'(obs_ack), 32'b010);
    check("prio_wr1", 32'({obs_wr_en, obs_wr_reg, obs_wr_data[7:0]}), 32'({1'b1, 4'd3, 8'h11}));
    cycle();
    check("prio_alu", 32'(obs_ack), 32'b100);
    check("prio_wr2", 32'({obs_wr_en, obs_wr_reg, obs_wr_data[7:0]}), 32'({1'b1, 4'd4, 8'h22}));
    cycle();
    check("prio_wr3", 32'({obs_wr_en, obs_wr_reg, obs_wr_data[7:0]}), 32'({1'b1, 4'd5, 8'h33}));
    put(SRC_ALU, 4'd6, 32'h66);
    for (int k = 0; k < 6; k++) begin
      if (!s_req[SRC_LD]) put(SRC_LD, 4'd8, 32'(k));
      cycle();
      check("aging", 32'(obs_ack), k == 4 ? 32'b100 : 32'b001);
    end
    c1 = 4'd7;
    sb_set = 1'b1;
    sb_reg = 4'd7;
    cycle();
    check("sb_haz0", 32'(obs_haz), 0);
    cycle();
    check("sb_haz1", 32'(obs_haz), 1);
    put(SRC_MD, 4'd7, 32'h77);
    cycle();
    check("sb_haz_ack", 32'(obs_haz), 1);
    cycle();
    check("sb_haz_wr", 32'(obs_haz), 1);
    cycle();
    check("sb_haz_clr", 32'(obs_haz), 0);
    c1 = 4'd0;
    sb_set = 1'b1;
    sb_reg = 4'd2;
    put(SRC_MD, 4'd2, 32'h2222);
    cycle();
    cycle();
    check("collision", 32'(obs_busy[2]), 1);
    put(SRC_LD, 4'd9, 32'h99);
    cycle();
    rst = 1'b1;
    cycle();
    check("midrst_wr_en", 32'(obs_wr_en), 0);
    check("midrst_busy", 32'(obs_busy), 0);
    rst = 1'b0;
    repeat (400) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (!s_req[i] && $urandom_range(0, 1) == 1) put(i, 4'($urandom), $urandom);
      sb_set = $urandom_range(0, 3) == 0;
      sb_reg = 4'($urandom);
      c1 = 4'($urandom);
      c2 = 4'($urandom);
      rst = $urandom_range(0, 99) == 0;
      cycle();
    end
    rst = 1'b0;
    repeat (10) cycle();
    check("drain", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
